// File: rtl/fifo_rd_pkg.sv
// Shared defaults and types for the FIFO read-side streamer.
package fifo_rd_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  // Occupancy of the two-entry prefetch buffer (0..2).
  typedef logic [1:0] occ_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order register buffer. slot0 is always the head; slot1 holds
// the second word when two are buffered. Push and pop in one cycle keep the
// occupancy unchanged and preserve order.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk2,
  input  logic                  rrst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  // Shift/insert words so slot0 always holds the oldest buffered word.
  always_ff @(posedge clk2 or posedge rrst) begin
    if (rrst) begin
      // NOTE: the data slots are reset (unusual for storage) because the
      // stream data output must read zero straight out of reset.
      slot0 <= '0;
      slot1 <= '0;
      occ   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments let slot0 take slot1's old value in
      // the same edge that slot1 takes the new word.
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          // occ is 1 or 2 here: pop requires a buffered word.
          if (occ == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-domain consumer of the async FIFO. Issues FIFO reads only when the
// word can be guaranteed a buffer slot two cycles later, hides the one-cycle
// read latency behind a two-entry prefetch buffer and counts delivered words.
module fifo_read_streamer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk2,
  input  logic                  rrst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  buf_empty
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic [2:0] level;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // Words that will occupy the buffer next cycle if no read is issued now.
  // pop implies occ >= 1, so this never underflows.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  // A read is only issued if its word is sure to find a free slot on arrival;
  // this is what makes buffer overflow impossible.
  assign fifo_rd_en = enable && !fifo_empty && !rrst && (level < 3'd2);

  assign buf_empty = (occ == 2'd0) && !inflight;

  // Remember that a read was issued: its data arrives on fifo_dout next cycle.
  always_ff @(posedge clk2 or posedge rrst) begin
    if (rrst) inflight <= 1'b0;
    else      inflight <= fifo_rd_en;
  end

  // Count delivered words; wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk2 or posedge rrst) begin
    if (rrst)     rd_count <= '0;
    else if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk2      (clk2),
    .rrst      (rrst),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

endmodule
